// File: rtl/flag_check_seq.sv
// Flag checker: streams candidate bytes through ROUNDS passes of the
// magic byte transform and compares each result with a programmed table.

// Combinational byte transform, one of four ops per pass.
module magic (
    input  logic [7:0] x,
    input  logic [1:0] op,
    output logic [7:0] y
);

    // Select the transform for this pass
    always_comb begin
        y = x;
        unique case (op)
            2'd0: y = {x[4:0], x[7:5]};
            2'd1: y = (x >> 2) ^ 8'h5A;
            2'd2: y = x + 8'd77;
            2'd3: y = x ^ 8'h33;
            default: y = x;
        endcase
    end

endmodule

module flag_check_seq #(
    parameter int LEN    = 16,
    parameter int IDX_W  = 4,
    parameter int ROUNDS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx,
    output logic             len_err
);

    localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_XFORM,
        S_CMP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [7:0]       work_q, work_d;
    logic             last_q, last_d;
    logic             mis_q, mis_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic             len_err_q, len_err_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic [7:0] exp_mem [2**IDX_W];
    logic [7:0] exp_byte;
    logic [7:0] magic_y;
    logic [1:0] op;
    logic       idle_or_done;
    logic       cfg_wr;
    logic       at_end;
    logic       mis_now;

    assign op           = 2'(idx_q) + 2'(rnd_q);
    assign exp_byte     = exp_mem[idx_q];
    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cfg_wr       = cfg_we && idle_or_done &&
                          ({1'b0, cfg_addr} < (IDX_W+1)'(LEN));
    assign at_end       = (idx_q == IDX_W'(LEN - 1));
    assign mis_now      = (work_q != exp_byte);

    magic u_magic (
        .x  (work_q),
        .op (op),
        .y  (magic_y)
    );

    // Expected table: survives reset, writable only while not checking
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            exp_mem[cfg_addr] <= cfg_data;
        end
    end

    // Next-state and next-output logic for the check sequencer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rnd_d      = rnd_q;
        work_d     = work_q;
        last_d     = last_q;
        mis_d      = mis_q;
        fail_idx_d = fail_idx_q;
        len_err_d  = len_err_q;
        pass_d     = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RECV;
                    idx_d      = '0;
                    mis_d      = 1'b0;
                    fail_idx_d = '0;
                    len_err_d  = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_RECV: begin
                if (in_valid) begin
                    work_d  = in_data;
                    last_d  = in_last;
                    rnd_d   = '0;
                    state_d = S_XFORM;
                end
            end
            S_XFORM: begin
                work_d = magic_y;
                if (rnd_q == RND_W'(ROUNDS - 1)) begin
                    state_d = S_CMP;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            S_CMP: begin
                if (mis_now && !mis_q) begin
                    mis_d      = 1'b1;
                    fail_idx_d = idx_q;
                end
                if (last_q || at_end) begin
                    state_d   = S_DONE;
                    len_err_d = (last_q != at_end);
                    pass_d    = !(mis_q || mis_now) && (last_q == at_end);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_RECV);
        busy_d     = (state_d == S_RECV) || (state_d == S_XFORM) ||
                     (state_d == S_CMP);
        done_d     = (state_d == S_DONE);
    end

    // Register state, datapath and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rnd_q      <= '0;
            work_q     <= '0;
            last_q     <= 1'b0;
            mis_q      <= 1'b0;
            fail_idx_q <= '0;
            len_err_q  <= 1'b0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rnd_q      <= rnd_d;
            work_q     <= work_d;
            last_q     <= last_d;
            mis_q      <= mis_d;
            fail_idx_q <= fail_idx_d;
            len_err_q  <= len_err_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_flag_check_seq.sv
// Bench for flag_check_seq: vector table of streams with a scoreboard
// of expected results, plus reset and length corner sequences.

module tb_flag_check_seq;

    localparam int LEN    = 4;
    localparam int IDX_W  = 4;
    localparam int ROUNDS = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [7:0]       cfg_data = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [IDX_W-1:0] fail_idx;
    logic             len_err;

    flag_check_seq #(
        .LEN    (LEN),
        .IDX_W  (IDX_W),
        .ROUNDS (ROUNDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_idx (fail_idx),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int hs_cyc = 0;

    typedef struct {
        logic [31:0]      data;
        int               n;
        bit               last_en;
        int               gap;
        bit               poke;
        bit               bstart;
        bit               exp_pass;
        bit               chk_fi;
        logic [IDX_W-1:0] exp_fi;
        bit               exp_len;
    } vec_t;

    typedef struct {
        bit               pass;
        bit               chk_fi;
        logic [IDX_W-1:0] fi;
        bit               len;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    logic [7:0] tab[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: got in_ready=0 expected 1");
        end
        hs_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit tcheck);
        int   t = 0;
        exp_t e;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got done=0 expected 1", name);
        end
        if (tcheck) chk({name, "_latency"}, cyc - hs_cyc, ROUNDS + 2);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb_empty: got 0 entries expected 1", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_pass"}, pass, e.pass);
            chk({name, "_len_err"}, len_err, e.len);
            if (e.chk_fi) chk({name, "_fail_idx"}, fail_idx, e.fi);
            chk({name, "_busy"}, busy, 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name,
                           input bit tcheck);
        exp_t e;
        e.pass   = v.exp_pass;
        e.chk_fi = v.chk_fi;
        e.fi     = v.exp_fi;
        e.len    = v.exp_len;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        chk({name, "_clr"}, {done, pass, len_err, fail_idx, busy, in_ready},
            {3'b000, 4'h0, 2'b11});
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.data[8*i +: 8], v.last_en && (i == v.n - 1));
            if (v.poke) begin
                cfg_we   = 1'b1;
                cfg_addr = IDX_W'(i);
                cfg_data = 8'hFF;
                @(negedge clk);
                cfg_we = 1'b0;
            end
            if (v.bstart && i == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat (v.gap) @(negedge clk);
        end
        wait_done(name, tcheck);
    endtask

    initial begin
        tab = '{8'h58, 8'h97, 8'hA3, 8'hBB};
        vecs[0] = '{32'h44434241, 4, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{32'h44584241, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        vecs[2] = '{32'h58584241, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        vecs[3] = '{32'h00434241, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[4] = '{32'h44434241, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[5] = '{32'h44434241, 4, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{32'h44434241, 4, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[7] = '{32'h44434258, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[8] = '{32'h00435841, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_state", {in_ready, busy, done, pass, len_err, fail_idx},
            '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = IDX_W'(i);
            cfg_data = tab[i];
            @(negedge clk);
        end
        cfg_addr = IDX_W'(4);
        cfg_data = 8'h00;
        @(negedge clk);
        cfg_addr = IDX_W'(3);
        cfg_data = tab[3];

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("v%0d", k), k == 0);
            if (k == 4) begin
                in_valid = 1'b1;
                in_data  = 8'h45;
                repeat (3) begin
                    chk("no_5th_byte", in_ready, 0);
                    @(negedge clk);
                end
                chk("v4_done_hold", done, 1);
                in_valid = 1'b0;
            end
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset", {in_ready, busy, done, pass, len_err, fail_idx},
            '0);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], "after_rst", 1'b1);
        run_vec(vecs[1], "rerun_fail", 1'b0);
        run_vec(vecs[0], "from_done", 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
